// File: rtl/div8_by4_seq.sv
// Sequential restoring divider, one quotient bit per clock.
// Valid/ready handshake on both the operand and the result side.
module div8_by4_seq #(
  parameter int DW = 8,
  parameter int VW = 4,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0] shreg;
  logic [DW-1:0] qreg;
  logic [VW-1:0] dvsr;
  logic [VW:0]   prem;
  logic [CW-1:0] count;

  logic [VW:0]   r_try;
  logic [VW:0]   r_sub;
  logic [VW:0]   prem_nxt;
  logic          q_bit;
  logic          last;

  // One restoring step: bring down the next dividend bit, trial-subtract.
  always_comb begin
    r_try    = {prem[VW-1:0], shreg[DW-1]};
    r_sub    = r_try - {1'b0, dvsr};
    q_bit    = (r_try >= {1'b0, dvsr});
    prem_nxt = q_bit ? r_sub : r_try;
    last     = (count == CW'(DW - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      qreg      <= '0;
      dvsr      <= '0;
      prem      <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= dividend;
            dvsr  <= divisor;
            prem  <= '0;
            qreg  <= '0;
            count <= '0;
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= '0;
              div_zero  <= 1'b1;
            end
          end
        end
        CALC: begin
          shreg <= shreg << 1;
          prem  <= prem_nxt;
          qreg  <= {qreg[DW-2:0], q_bit};
          if (last) begin
            quotient  <= {qreg[DW-2:0], q_bit};
            remainder <= prem_nxt[VW-1:0];
            div_zero  <= 1'b0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div8_by4_seq.sv
// Directed and sweep bench for div8_by4_seq.
// Vector table, hand sequences for stall/reset, full operand sweep.
module tb_div8_by4_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_zero;

  div8_by4_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  int checks = 0;
  int errors = 0;

  logic [7:0] got_q;
  logic [3:0] got_r;
  logic       got_dz;
  int         got_lat;
  logic       timed_out;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Latency counts clock edges after the accepting edge until out_valid is seen.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                        input int stall);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    in_valid = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    got_lat  = 0;
    while (!out_valid && got_lat < 20) begin
      tick();
      got_lat++;
    end
    timed_out = !out_valid;
    for (int i = 0; i < stall; i++) tick();
    got_q  = quotient;
    got_r  = remainder;
    got_dz = div_zero;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] q0;
    logic [3:0] r0;
    logic       dz0;
    logic       stable;
    logic       rdy_seen;
    logic       ov_seen;
    logic [7:0] eq;
    logic [3:0] er;
    logic       edz;

    vecs[0] = '{8'd143, 4'd11, 8'd13,  4'd0,  1'b0, 8};
    vecs[1] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0, 8};
    vecs[2] = '{8'd7,   4'd9,  8'd0,   4'd7,  1'b0, 8};
    vecs[3] = '{8'd250, 4'd15, 8'd16,  4'd10, 1'b0, 8};
    vecs[4] = '{8'd200, 4'd0,  8'hFF,  4'd0,  1'b1, 0};
    vecs[5] = '{8'd100, 4'd3,  8'd33,  4'd1,  1'b0, 8};
    vecs[6] = '{8'd0,   4'd5,  8'd0,   4'd0,  1'b0, 8};
    vecs[7] = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 8};
    vecs[8] = '{8'd15,  4'd4,  8'd3,   4'd3,  1'b0, 8};
    vecs[9] = '{8'd128, 4'd7,  8'd18,  4'd2,  1'b0, 8};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("reset_in_ready",  int'(in_ready),  1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_quotient",  int'(quotient),  0);
    chk("reset_remainder", int'(remainder), 0);
    chk("reset_div_zero",  int'(div_zero),  0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, i % 3);
      chk($sformatf("vec%0d_latency", i), got_lat, vecs[i].lat);
      chk($sformatf("vec%0d_q", i), int'(got_q), int'(vecs[i].q));
      chk($sformatf("vec%0d_r", i), int'(got_r), int'(vecs[i].r));
      chk($sformatf("vec%0d_dz", i), int'(got_dz), int'(vecs[i].dz));
      chk($sformatf("vec%0d_ready_after", i), int'(in_ready), 1);
    end

    // Back-pressure in DONE while inputs churn.
    in_valid = 1'b1;
    dividend = 8'd250;
    divisor  = 4'd15;
    tick();
    in_valid = 1'b0;
    for (int n = 0; n < 20 && !out_valid; n++) tick();
    chk("stall_reach_done", int'(out_valid), 1);
    q0 = quotient;
    r0 = remainder;
    dz0 = div_zero;
    stable = 1'b1;
    rdy_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
      tick();
      if (quotient != q0 || remainder != r0 || div_zero != dz0 ||
          !out_valid)
        stable = 1'b0;
      if (in_ready) rdy_seen = 1'b1;
    end
    chk("stall_outputs_stable", int'(stable), 1);
    chk("stall_in_ready_low", int'(rdy_seen), 0);
    chk("stall_q_value", int'(q0), 16);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stall_handshake_ov", int'(out_valid), 0);
    chk("stall_handshake_ready", int'(in_ready), 1);
    ov_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid) ov_seen = 1'b1;
    end
    chk("stall_no_new_op", int'(ov_seen), 0);

    // Reset landing on the 4th CALC edge of 100/3.
    in_valid = 1'b1;
    dividend = 8'd100;
    divisor  = 4'd3;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midcalc_rst_ready", int'(in_ready), 1);
    chk("midcalc_rst_ov", int'(out_valid), 0);
    chk("midcalc_rst_q", int'(quotient), 0);
    ov_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) ov_seen = 1'b1;
    end
    chk("midcalc_rst_no_valid", int'(ov_seen), 0);
    run_op(8'd100, 4'd3, 0);
    chk("after_rst_q", int'(got_q), 33);
    chk("after_rst_r", int'(got_r), 1);

    // Full operand sweep with random result stalls.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          eq = 8'hFF;
          er = 4'd0;
          edz = 1'b1;
        end else begin
          eq = 8'(a / b);
          er = 4'(a % b);
          edz = 1'b0;
        end
        run_op(8'(a), 4'(b), int'($urandom_range(0, 2)));
        chk($sformatf("sweep_%0d_%0d", a, b),
            int'({timed_out, got_dz, got_q, got_r}),
            int'({1'b0, edz, eq, er}));
      end
    end

    // Round-trip of 4x4 multiplier products.
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op(8'(a * b), 4'(b), 0);
        chk($sformatf("product_%0dx%0d", a, b),
            int'({timed_out, got_dz, got_q, got_r}),
            int'({1'b0, 1'b0, 8'(a), 4'd0}));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
